// File: rtl/single_multiply_v_s_lanes.sv
// single_multiply_v_s_lanes: vector-by-scalar IEEE-754 single multiply, LANES elements per cycle.
// Flush-to-zero, round-to-nearest-even, canonical quiet NaN, optional result negation.
module single_multiply_v_s_lanes #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] vector_a [WIDTH],
  input  logic [31:0] b,
  input  logic        negate,
  output logic        busy,
  output logic        done,
  output logic [31:0] vector_c [WIDTH]
);
  localparam int N  = (LANES > 0) ? WIDTH / LANES : 1;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  if (LANES < 1 || WIDTH < 1 || (WIDTH % LANES) != 0) begin : g_bad_params
    $error("WIDTH must be >= 1 and an exact multiple of LANES");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [GW-1:0] grp;
  logic [31:0] a_r [WIDTH];
  logic [31:0] b_r;
  logic        neg_r;
  logic [31:0] prod [LANES];

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y, input logic neg);
    logic s, xz, yz, xi, yi, xn, yn, g, st, up;
    logic [47:0] p;
    logic [22:0] m;
    logic [24:0] r;
    logic signed [9:0] e;
    s  = x[31] ^ y[31] ^ neg;
    xz = x[30:23] == 8'd0;
    yz = y[30:23] == 8'd0;
    xi = (&x[30:23]) && x[22:0] == 23'd0;
    yi = (&y[30:23]) && y[22:0] == 23'd0;
    xn = (&x[30:23]) && (|x[22:0]);
    yn = (&y[30:23]) && (|y[22:0]);
    p  = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    m  = p[47] ? p[46:24] : p[45:23];
    g  = p[47] ? p[23] : p[22];
    st = p[47] ? (|p[22:0]) : (|p[21:0]);
    up = g & (st | m[0]);
    r  = {2'b01, m} + {24'd0, up};
    // a rounding carry out of the mantissa bumps the exponent once more
    e  = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127
       + $signed({9'd0, p[47]}) + $signed({9'd0, r[24]});
    if (xn || yn || (xi && yz) || (yi && xz)) fmul = 32'h7FC0_0000;
    else if (xi || yi)                        fmul = {s, 8'hFF, 23'd0};
    else if (xz || yz)                        fmul = {s, 31'd0};
    else if (e >= 10'sd255)                   fmul = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                     fmul = {s, 31'd0};
    else                                      fmul = {s, e[7:0], r[24] ? r[23:1] : r[22:0]};
  endfunction

  always_comb
    for (int l = 0; l < LANES; l++)
      prod[l] = fmul(a_r[int'(grp) * LANES + l], b_r, neg_r);

  assign busy = state == RUN;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      grp      <= '0;
      a_r      <= '{default: '0};
      b_r      <= '0;
      neg_r    <= 1'b0;
      vector_c <= '{default: '0};
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r   <= vector_a;
          b_r   <= b;
          neg_r <= negate;
          grp   <= '0;
          state <= RUN;
        end
        RUN: begin
          for (int l = 0; l < LANES; l++)
            vector_c[int'(grp) * LANES + l] <= prod[l];
          grp <= grp + 1'b1;
          if (grp == GW'(N - 1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/single_multiply_v_s_lanes.md
SINGLE_MULTIPLY_V_S_LANES -- requirements
Module: single_multiply_v_s_lanes

Interface
REQ-001 Parameter WIDTH, default 8, number of vector elements; SHALL be >= 1.
REQ-002 Parameter LANES, default 2, elements computed per cycle; SHALL divide WIDTH exactly (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request; sampled only when idle.
REQ-006 vector_a  input  32 x [WIDTH] unpacked array  IEEE-754 single operands; sampled with start.
REQ-007 b  input  32  IEEE-754 single scalar; sampled with start.
REQ-008 negate  input  1  sampled with start; 1 = results are -(a*b).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse; all WIDTH results valid.
REQ-011 vector_c  output  32 x [WIDTH] unpacked array  registered products.

Function
REQ-012 FSM states: IDLE, RUN; N = WIDTH/LANES groups.
REQ-013 IDLE: start=1 at edge T latches vector_a, b and negate into internal registers, clears group index, enters RUN; start=0 holds IDLE.
REQ-014 RUN: at edge T+1+k (k=0..N-1) elements k*LANES .. k*LANES+LANES-1 of vector_c are written; group index increments.
REQ-015 At edge T+N (last group written) state returns to IDLE and done is registered high for exactly one cycle.
REQ-016 Latency: done high during the cycle following edge T+N; WIDTH=LANES gives done one cycle after start.
REQ-017 busy = (state == RUN); low in the cycle done is high.
REQ-018 start while in RUN is ignored; latched operands unaffected; input changes after edge T are ignored.
REQ-019 start in the cycle done is high is accepted (back-to-back, no bubble).
REQ-020 Elements of vector_c not yet rewritten retain prior values; each element changes only on its group's write edge.
REQ-021 Product: sign = sign(a) xor sign(b) xor negate; 24x24-bit mantissa product with hidden bit, normalise by at most one bit, round to nearest, ties to even.
REQ-022 Subnormal inputs are flushed to signed zero before multiplying; subnormal or underflowing results flush to signed zero.
REQ-023 Exponent overflow after rounding gives signed infinity (exp 0xFF, mantissa 0).
REQ-024 Any NaN input, or infinity x zero, gives canonical quiet NaN 0x7FC00000 (negate not applied).
REQ-025 Infinity x finite nonzero gives signed infinity; zero x finite gives signed zero.
REQ-026 The LANES multipliers are combinational from latched registers to vector_c; no other pipeline stages.

Reset
REQ-027 rstn low immediately forces state IDLE, busy=0, done=0, every vector_c element 0x00000000, group index 0, operand registers 0.
REQ-028 Reset during RUN abandons the operation; no done pulse follows; after rstn rises, the block waits in IDLE for a new start.
REQ-029 start is ignored while rstn is low.

Verification
REQ-030 WIDTH=4, LANES=2, a={1.0,2.0,3.0,4.0}, b=2.0, negate=0 -> c={0x40000000,0x40800000,0x40C00000,0x41000000}; c[0..1] at edge T+1, c[2..3] and done at edge T+2; busy high for 2 cycles.
REQ-031 Same, negate=1, b=1.5, a={1.5,-1.0,0.0,0x3F800001} -> c={0xC0100000,0x3FC00000,0x80000000,0xBFC00002}.
REQ-032 Specials: a={0x7F800000,0x7F7FFFFF,0x7FC12345,0x00400000}, b=0.0 -> {0x7FC00000,0x00000000,0x7FC00000,0x00000000}; b=2.0 -> {0x7F800000,0x7F800000,0x7FC00000,0x00000000}.
REQ-033 Rounding: a=0x3F800001, b=0x3F800001 -> 0x3F800002; a=0x3FFFFFFF, b=0x3FFFFFFF -> 0x407FFFFE.
REQ-034 start pulsed again at edge T+1 with different operands -> ignored, results per first operands; start at the done cycle -> second operation completes 2 cycles later with its own results.
REQ-035 rstn low after edge T+1 -> vector_c all zero, busy=0, no done pulse; new start after release completes normally.
